// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
// Issue sequencer for an external SM83 ALU: accepts one ALU-class opcode, fetches an
// (HL) operand when needed, drives the ALU for one cycle and writes the result back.
module alu_sequencer #(
    parameter bit POST_BOOT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        insValid,
    output logic        insReady,
    input  logic [7:0]  insOpcode,
    input  logic        insCb,
    input  logic [7:0]  insImm,
    input  logic [15:0] spIn,
    output logic [7:0]  aluOp,
    output logic [15:0] aluX,
    output logic [15:0] aluY,
    output logic [3:0]  aluFIn,
    input  logic [15:0] aluO,
    input  logic [3:0]  aluFOut,
    output logic [15:0] memAddr,
    output logic        memRe,
    output logic        memWe,
    output logic [7:0]  memWData,
    input  logic [7:0]  memRData,
    input  logic        memAck,
    output logic        done,
    output logic        illegal,
    output logic [63:0] regsOut
);
    localparam int unsigned DW = 8;
    localparam int unsigned WW = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MEM_RD = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM_WR = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // Register slots follow the r operand code (B,C,D,E,H,L,-,A); slot 6 holds F
    // because r=6 always means (HL) and never names a register.
    localparam logic [2:0] R_B = 3'd0, R_C = 3'd1, R_D = 3'd2, R_E = 3'd3;
    localparam logic [2:0] R_H = 3'd4, R_L = 3'd5, R_F = 3'd6, R_A = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] opc_q, opc_d, imm_q, imm_d, mem_q, mem_d, wdata_q, wdata_d;
    logic          cb_q, cb_d, bad_q, bad_d;
    logic          rdy_q, done_q, illegal_q, mem_re_q, mem_we_q;
    logic [DW-1:0] alu_op_q, alu_op_c;
    logic [WW-1:0] alu_x_q, alu_x_c, alu_y_q, alu_y_c;
    logic [3:0]    alu_fin_q, alu_fin_c;
    logic [DW-1:0] rf_q [8];
    logic [DW-1:0] rf_d [8];
    logic [2:0]    r_sel;
    logic [DW-1:0] r_val;
    logic [3:0]    f_old;

    function automatic logic supported(input logic cb, input logic [7:0] opc);
        return cb || (opc[7:6] == 2'b10)
            || (opc[7:6] == 2'b11 && opc[2:0] == 3'b110)
            || (opc[7:6] == 2'b00 && opc[2:0] == 3'b111)
            || (opc[7:6] == 2'b00 && opc[3:0] == 4'b1001);
    endfunction

    function automatic logic mem_operand(input logic cb, input logic [7:0] opc);
        return (cb || opc[7:6] == 2'b10) && opc[2:0] == 3'b110;
    endfunction

    function automatic logic [7:0] reset_value(input logic [2:0] slot);
        logic [7:0] v;
        case (slot)
            R_C:     v = 8'h13;
            R_E:     v = 8'hD8;
            R_H:     v = 8'h01;
            R_L:     v = 8'h4D;
            R_F:     v = 8'hB0;
            R_A:     v = 8'h01;
            default: v = 8'h00;
        endcase
        return POST_BOOT ? v : 8'h00;
    endfunction

    // Next state, operand selection and writeback.
    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        cb_d      = cb_q;
        imm_d     = imm_q;
        mem_d     = mem_q;
        wdata_d   = wdata_q;
        bad_d     = bad_q;
        alu_op_c  = alu_op_q;
        alu_x_c   = alu_x_q;
        alu_y_c   = alu_y_q;
        alu_fin_c = alu_fin_q;
        rf_d      = rf_q;
        r_sel     = opc_q[2:0];
        r_val     = (r_sel == 3'd6) ? mem_q : rf_q[r_sel];
        f_old     = rf_q[R_F][7:4];

        case (state_q)
            S_IDLE: begin
                if (insValid) begin
                    opc_d = insOpcode;
                    cb_d  = insCb;
                    imm_d = insImm;
                    bad_d = !supported(insCb, insOpcode);
                    if (!supported(insCb, insOpcode))        state_d = S_DONE;
                    else if (mem_operand(insCb, insOpcode))  state_d = S_MEM_RD;
                    else                                     state_d = S_EXEC;
                end
            end
            S_MEM_RD: begin
                if (memAck) begin
                    mem_d   = memRData;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d   = S_DONE;
                alu_fin_c = f_old;
                alu_x_c   = WW'(r_val);
                alu_y_c   = '0;
                if (cb_q) begin
                    case (opc_q[7:6])
                        2'b00:   alu_op_c = opc_q[5] ? (8'h24 | 8'({opc_q[4], opc_q[4] ^ opc_q[3]}))
                                                     : (8'h10 | 8'(opc_q[4:3]));
                        2'b01:   alu_op_c = 8'h30 | 8'(opc_q[5:3]);
                        2'b10:   alu_op_c = 8'h40 | 8'(opc_q[5:3]);
                        default: alu_op_c = 8'h50 | 8'(opc_q[5:3]);
                    endcase
                    if (opc_q[7:6] == 2'b01) begin
                        rf_d[R_F] = {aluFOut[3], 1'b0, 1'b1, f_old[0], 4'h0};
                    end else begin
                        if (opc_q[7:6] == 2'b00) rf_d[R_F] = {aluFOut, 4'h0};
                        if (r_sel == 3'd6) begin
                            wdata_d = aluO[7:0];
                            state_d = S_MEM_WR;
                        end else begin
                            rf_d[r_sel] = aluO[7:0];
                        end
                    end
                end else if (opc_q[7]) begin
                    // CP goes out as SUB; only its flags are kept.
                    alu_op_c = (opc_q[5:3] == 3'd7) ? 8'h02 : 8'(opc_q[5:3]);
                    alu_x_c  = WW'(rf_q[R_A]);
                    alu_y_c  = opc_q[6] ? WW'(imm_q) : WW'(r_val);
                    if (opc_q[5:3] != 3'd7) rf_d[R_A] = aluO[7:0];
                    rf_d[R_F] = {aluFOut, 4'h0};
                end else if (opc_q[2:0] == 3'b111) begin
                    alu_op_c  = (opc_q[5] ? 8'h14 : 8'h10) | 8'(opc_q[4:3]);
                    alu_x_c   = WW'(rf_q[R_A]);
                    rf_d[R_A] = aluO[7:0];
                    if (!opc_q[5])                 rf_d[R_F] = {1'b0, aluFOut[2:0], 4'h0};
                    else if (opc_q[4:3] == 2'b01)  rf_d[R_F] = {f_old[3], 2'b11, f_old[0], 4'h0};
                    else                           rf_d[R_F] = {aluFOut, 4'h0};
                end else begin
                    alu_op_c = 8'h60;
                    alu_x_c  = {rf_q[R_H], rf_q[R_L]};
                    case (opc_q[5:4])
                        2'b00:   alu_y_c = {rf_q[R_B], rf_q[R_C]};
                        2'b01:   alu_y_c = {rf_q[R_D], rf_q[R_E]};
                        2'b10:   alu_y_c = {rf_q[R_H], rf_q[R_L]};
                        default: alu_y_c = spIn;
                    endcase
                    rf_d[R_H] = aluO[15:8];
                    rf_d[R_L] = aluO[7:0];
                    rf_d[R_F] = {f_old[3], 1'b0, aluFOut[1:0], 4'h0};
                end
            end
            S_MEM_WR: if (memAck) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            opc_q     <= '0;
            cb_q      <= 1'b0;
            imm_q     <= '0;
            mem_q     <= '0;
            wdata_q   <= '0;
            bad_q     <= 1'b0;
            rdy_q     <= 1'b1;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            mem_re_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            alu_op_q  <= '0;
            alu_x_q   <= '0;
            alu_y_q   <= '0;
            alu_fin_q <= '0;
            for (int i = 0; i < 8; i++) rf_q[i] <= reset_value(3'(i));
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            cb_q      <= cb_d;
            imm_q     <= imm_d;
            mem_q     <= mem_d;
            wdata_q   <= wdata_d;
            bad_q     <= bad_d;
            rdy_q     <= (state_d == S_IDLE);
            done_q    <= (state_d == S_DONE);
            illegal_q <= (state_d == S_DONE) && bad_d;
            mem_re_q  <= (state_d == S_MEM_RD);
            mem_we_q  <= (state_d == S_MEM_WR);
            alu_op_q  <= alu_op_c;
            alu_x_q   <= alu_x_c;
            alu_y_q   <= alu_y_c;
            alu_fin_q <= alu_fin_c;
            for (int i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign insReady = rdy_q;
    assign done     = done_q;
    assign illegal  = illegal_q;
    assign memRe    = mem_re_q;
    assign memWe    = mem_we_q;
    assign memWData = wdata_q;
    assign memAddr  = {rf_q[R_H], rf_q[R_L]};
    assign aluOp    = alu_op_c;
    assign aluX     = alu_x_c;
    assign aluY     = alu_y_c;
    assign aluFIn   = alu_fin_c;
    assign regsOut  = {rf_q[R_A], rf_q[R_F], rf_q[R_B], rf_q[R_C],
                       rf_q[R_D], rf_q[R_E], rf_q[R_H], rf_q[R_L]};

endmodule

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
// Directed bench for alu_sequencer with a behavioural SM83 ALU subset and a
// delayed-ack single-port memory responder.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        insValid, insCb;
    logic        insReady;
    logic [7:0]  insOpcode, insImm;
    logic [15:0] spIn;
    logic [7:0]  aluOp;
    logic [15:0] aluX, aluY, aluO;
    logic [3:0]  aluFIn, aluFOut;
    logic [15:0] memAddr;
    logic        memRe, memWe, memAck;
    logic [7:0]  memWData, memRData;
    logic        done, illegal;
    logic [63:0] regsOut;

    always #5 clk = ~clk;

    alu_sequencer #(.POST_BOOT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .insValid(insValid), .insReady(insReady), .insOpcode(insOpcode),
        .insCb(insCb), .insImm(insImm), .spIn(spIn),
        .aluOp(aluOp), .aluX(aluX), .aluY(aluY), .aluFIn(aluFIn),
        .aluO(aluO), .aluFOut(aluFOut),
        .memAddr(memAddr), .memRe(memRe), .memWe(memWe), .memWData(memWData),
        .memRData(memRData), .memAck(memAck),
        .done(done), .illegal(illegal), .regsOut(regsOut)
    );

    logic [7:0] r_a, r_f, r_h, r_l;
    assign r_a = regsOut[63:56];
    assign r_f = regsOut[55:48];
    assign r_h = regsOut[15:8];
    assign r_l = regsOut[7:0];

    // Reference ALU: only the operations this bench issues.
    logic [8:0]  sum9, dif9;
    logic [16:0] sum17;
    always_comb begin
        sum9    = 9'(aluX[7:0]) + 9'(aluY[7:0]);
        dif9    = 9'(aluX[7:0]) - 9'(aluY[7:0]);
        sum17   = 17'(aluX) + 17'(aluY);
        aluO    = aluX;
        aluFOut = aluFIn;
        case (aluOp)
            8'h00: begin
                aluO    = 16'(sum9[7:0]);
                aluFOut = {sum9[7:0] == 8'h00, 1'b0, (5'(aluX[3:0]) + 5'(aluY[3:0])) > 5'h0F, sum9[8]};
            end
            8'h02: begin
                aluO    = 16'(dif9[7:0]);
                aluFOut = {dif9[7:0] == 8'h00, 1'b1, aluX[3:0] < aluY[3:0], aluX[7:0] < aluY[7:0]};
            end
            8'h05: begin
                aluO    = 16'(aluX[7:0] ^ aluY[7:0]);
                aluFOut = {(aluX[7:0] ^ aluY[7:0]) == 8'h00, 3'b000};
            end
            8'h06: begin
                aluO    = 16'(aluX[7:0] | aluY[7:0]);
                aluFOut = {(aluX[7:0] | aluY[7:0]) == 8'h00, 3'b000};
            end
            8'h10: begin
                aluO    = 16'({aluX[6:0], aluX[7]});
                aluFOut = {aluX[7:0] == 8'h00, 2'b00, aluX[7]};
            end
            8'h15: begin
                aluO    = 16'(~aluX[7:0]);
                aluFOut = {aluFIn[3], 2'b11, aluFIn[0]};
            end
            8'h16: aluFOut = {aluFIn[3], 3'b001};
            8'h27: begin
                aluO    = 16'({aluX[3:0], aluX[7:4]});
                aluFOut = {aluX[7:0] == 8'h00, 3'b000};
            end
            8'h60: begin
                aluO    = sum17[15:0];
                aluFOut = {aluFIn[3], 1'b0, (13'(aluX[11:0]) + 13'(aluY[11:0])) > 13'h0FFF, sum17[16]};
            end
            default: begin
                if (aluOp[7:4] == 4'h3) aluFOut = {~aluX[aluOp[2:0]], 2'b01, aluFIn[0]};
                if (aluOp[7:4] == 4'h4) aluO = 16'(aluX[7:0] & ~(8'h01 << aluOp[2:0]));
                if (aluOp[7:4] == 4'h5) aluO = 16'(aluX[7:0] | (8'h01 << aluOp[2:0]));
            end
        endcase
    end

    // Memory responder: ack after ack_dly cycles of a held request, for one cycle.
    int         ack_dly, ack_cnt;
    int         wr_cnt;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data, rd_val;
    always @(negedge clk) begin
        if (memAck) begin
            memAck  = 1'b0;
            ack_cnt = 0;
        end else if (memRe || memWe) begin
            if (ack_cnt == ack_dly) begin
                memAck   = 1'b1;
                memRData = rd_val;
                if (memWe) begin
                    wr_addr = memAddr;
                    wr_data = memWData;
                    wr_cnt++;
                end
            end else begin
                ack_cnt++;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    int re_total, we_total;
    always @(posedge clk) begin
        if (memRe) re_total++;
        if (memWe) we_total++;
    end

    int n_checks, n_fail;
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int   op_lat, re_n, we_n;
    logic op_ill, op_rdy_done, op_rdy_after;
    task automatic run_op(input logic cb, input logic [7:0] opc, input logic [7:0] imm);
        int re0, we0;
        @(negedge clk);
        insValid = 1'b1; insCb = cb; insOpcode = opc; insImm = imm;
        @(posedge clk);
        #1;
        re0 = re_total; we0 = we_total;
        insValid = 1'b0; insCb = ~cb; insOpcode = 8'hD3; insImm = ~imm;
        op_lat = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (done) begin
                op_lat = k; op_ill = illegal; op_rdy_done = insReady;
                break;
            end
        end
        if (op_lat == 0) check_eq("done_timeout", 64'(done), 64'h1);
        else begin
            @(negedge clk);
            op_rdy_after = insReady;
        end
        re_n = re_total - re0;
        we_n = we_total - we0;
    endtask

    // Build a register value bit by bit with RES/SET, which leave F alone.
    task automatic load_reg(input logic [2:0] r, input logic [7:0] v);
        for (int b = 0; b < 8; b++) run_op(1'b1, {(v[b] ? 2'b11 : 2'b10), 3'(b), r}, 8'h00);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; re_total = 0; we_total = 0;
        rst_n = 1'b0; insValid = 1'b0; insCb = 1'b0; insOpcode = 8'h00; insImm = 8'h00;
        spIn = 16'hFFFE; memAck = 1'b0; memRData = 8'h00; rd_val = 8'hF1;
        ack_dly = 2; ack_cnt = 0; wr_cnt = 0; wr_addr = 16'h0; wr_data = 8'h0;
        #12;
        check_eq("rst_ready", 64'(insReady), 64'h1);
        check_eq("rst_done_ill_re_we", 64'({done, illegal, memRe, memWe}), 64'h0);
        check_eq("rst_alu", 64'({aluOp, aluX, aluY, aluFIn}), 64'h0);
        check_eq("rst_regs", regsOut, 64'h01B0_0013_00D8_014D);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD A,B
        load_reg(3'd7, 8'h3A);
        load_reg(3'd0, 8'hC6);
        run_op(1'b0, 8'h80, 8'h00);
        check_eq("add_latency", 64'(op_lat), 64'd2);
        check_eq("add_ready_at_done", 64'(op_rdy_done), 64'h0);
        check_eq("add_ready_after", 64'(op_rdy_after), 64'h1);
        check_eq("add_illegal", 64'(op_ill), 64'h0);
        check_eq("add_a_f", 64'({r_a, r_f}), 64'h00B0);

        // CP A,imm
        load_reg(3'd7, 8'h3C);
        run_op(1'b0, 8'hFE, 8'h40);
        check_eq("cp_a_f", 64'({r_a, r_f}), 64'h3C50);
        check_eq("cp_aluop", 64'(aluOp), 64'h02);
        check_eq("cp_aluy", 64'(aluY), 64'h0040);

        // SWAP (HL) with two-cycle memory latency on both accesses
        load_reg(3'd4, 8'hC0);
        load_reg(3'd5, 8'h00);
        begin : swap_hl
            int w0;
            w0 = wr_cnt;
            run_op(1'b1, 8'h36, 8'h00);
            check_eq("swap_writes", 64'(wr_cnt - w0), 64'd1);
        end
        check_eq("swap_re_cycles", 64'(re_n), 64'd3);
        check_eq("swap_we_cycles", 64'(we_n), 64'd3);
        check_eq("swap_wr_addr", 64'(wr_addr), 64'hC000);
        check_eq("swap_wr_data", 64'(wr_data), 64'h1F);
        check_eq("swap_latency", 64'(op_lat), 64'd8);
        check_eq("swap_f_hl", 64'({r_f, r_h, r_l}), 64'h00C000);

        // BIT 7,H then SET 7,H
        load_reg(3'd4, 8'h01);
        run_op(1'b0, 8'hF6, 8'h01);
        run_op(1'b0, 8'h37, 8'h00);
        check_eq("scf_f", 64'(r_f), 64'h10);
        run_op(1'b1, 8'h7C, 8'h00);
        check_eq("bit_f_h", 64'({r_f, r_h}), 64'hB001);
        run_op(1'b1, 8'hFC, 8'h00);
        check_eq("set_f_h", 64'({r_f, r_h}), 64'hB081);

        // RLCA on zero: Z must come back clear
        run_op(1'b0, 8'hAF, 8'h00);
        check_eq("xor_a_f", 64'({r_a, r_f}), 64'h0080);
        run_op(1'b0, 8'h07, 8'h00);
        check_eq("rlca_a_f", 64'({r_a, r_f}), 64'h0000);

        // ADD HL,HL then CPL
        run_op(1'b0, 8'hAF, 8'h00);
        load_reg(3'd4, 8'h8F);
        load_reg(3'd5, 8'hFF);
        run_op(1'b0, 8'h29, 8'h00);
        check_eq("add16_hl_f", 64'({r_h, r_l, r_f}), 64'h1FFEB0);
        check_eq("add16_aluop", 64'(aluOp), 64'h60);
        load_reg(3'd7, 8'h35);
        run_op(1'b0, 8'h2F, 8'h00);
        check_eq("cpl_a_f", 64'({r_a, r_f}), 64'hCAF0);

        // Asynchronous reset while a memory read is outstanding
        ack_dly = 20;
        @(negedge clk);
        insValid = 1'b1; insCb = 1'b0; insOpcode = 8'h86; insImm = 8'h00;
        @(posedge clk);
        #1;
        insValid = 1'b0;
        @(negedge clk);
        check_eq("mid_rd_re", 64'(memRe), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_re", 64'(memRe), 64'h0);
        check_eq("async_rst_ready", 64'(insReady), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        ack_dly = 2;
        @(negedge clk);
        check_eq("post_rst_ready", 64'(insReady), 64'h1);
        check_eq("post_rst_regs", regsOut, 64'h01B0_0013_00D8_014D);

        // Unsupported opcode
        run_op(1'b0, 8'hD3, 8'h00);
        check_eq("ill_latency", 64'(op_lat), 64'd1);
        check_eq("ill_pulse", 64'(op_ill), 64'h1);
        check_eq("ill_regs", regsOut, 64'h01B0_0013_00D8_014D);
        check_eq("ill_clears", 64'({done, illegal}), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
